// File: rtl/dtw_pkg.sv
// Shared definitions for the DTW result path: unpacker state encoding and the
// record word order used by the core-side serialiser.
package dtw_pkg;

  // Read states share their encoding with the word index they consume.
  typedef enum logic [1:0] {
    S_QID = 2'd0,
    S_POS = 2'd1,
    S_VAL = 2'd2,
    S_OUT = 2'd3
  } state_t;

  localparam logic [1:0] WORD_QID = 2'd0;
  localparam logic [1:0] WORD_POS = 2'd1;
  localparam logic [1:0] WORD_VAL = 2'd2;

  localparam int unsigned REC_WORDS = 3;

  // True for states that pop a FIFO word.
  function automatic logic is_read_state(state_t s);
    return (s != S_OUT);
  endfunction

endpackage

// File: rtl/dtw_result_unpacker_if.sv
// Result record handshake between the unpacker and host-side logic.
interface dtw_result_unpacker_if #(
  parameter int unsigned dtw_dwidth = 16,
  parameter int unsigned axi_dwidth = 32
);

  logic                  res_valid;
  logic                  res_ready;
  logic [axi_dwidth-1:0] res_qid;
  logic [axi_dwidth-1:0] res_position;
  logic [dtw_dwidth-1:0] res_minval;
  logic                  res_hit;

  modport master (
    output res_valid,
    output res_qid,
    output res_position,
    output res_minval,
    output res_hit,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_qid,
    input  res_position,
    input  res_minval,
    input  res_hit,
    output res_ready
  );

endinterface

// File: rtl/dtw_sat_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones.
module dtw_sat_counter #(
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [width-1:0] count
);

  // Clear wins over increment; increment stops at the maximum value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {width{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/dtw_result_unpacker.sv
// Pops 3-word DTW result records from a FWFT FIFO, reassembles them, applies
// an optional cost-threshold filter and presents kept records over valid/ready.
module dtw_result_unpacker
  import dtw_pkg::*;
#(
  parameter int unsigned dtw_dwidth = 16,
  parameter int unsigned axi_dwidth = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   filter_en,
  input  logic [axi_dwidth-1:0]  threshold,
  output logic                   fifo_rden,
  input  logic                   fifo_empty,
  input  logic [axi_dwidth-1:0]  fifo_data,
  dtw_result_unpacker_if.master  res,
  output logic [axi_dwidth-1:0]  rec_count,
  output logic [axi_dwidth-1:0]  hit_count,
  output logic                   fmt_err
);

  state_t state_q, state_d;

  logic                  pop;
  logic [1:0]            word_sel;
  logic [dtw_dwidth-1:0] cost;
  logic                  cost_hit;
  logic                  cost_bad;
  logic                  val_pop;
  logic                  unused_thr;

  logic [axi_dwidth-1:0] qid_q;
  logic [axi_dwidth-1:0] position_q;
  logic [dtw_dwidth-1:0] minval_q;
  logic                  hit_q;
  logic                  fmt_err_q;

  // Only the low cost bits of the threshold take part in the compare.
  assign unused_thr = ^threshold[axi_dwidth-1:dtw_dwidth];

  assign word_sel = state_q;
  assign cost     = fifo_data[dtw_dwidth-1:0];
  assign cost_hit = (cost < threshold[dtw_dwidth-1:0]);
  assign cost_bad = (fifo_data[axi_dwidth-1:dtw_dwidth] != '0);
  assign val_pop  = pop && (state_q == S_VAL);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_QID;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear aborts any record in progress.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_QID;
    end else begin
      unique case (state_q)
        S_QID: if (pop) state_d = S_POS;
        S_POS: if (pop) state_d = S_VAL;
        S_VAL: begin
          if (pop) begin
            state_d = (filter_en && !cost_hit) ? S_QID : S_OUT;
          end
        end
        S_OUT: if (res.res_ready) state_d = S_QID;
        default: state_d = S_QID;
      endcase
    end
  end

  // Outputs: pop only in a read state with data, never during reset or clear.
  always_comb begin
    pop = 1'b0;
    if (rst_n && !clear && !fifo_empty && is_read_state(state_q)) begin
      pop = 1'b1;
    end
    fifo_rden     = pop;
    res.res_valid = (state_q == S_OUT);
  end

  // Record fields are captured word by word as they are popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qid_q      <= '0;
      position_q <= '0;
      minval_q   <= '0;
      hit_q      <= 1'b0;
    end else if (pop) begin
      unique case (word_sel)
        WORD_QID: qid_q <= fifo_data;
        WORD_POS: position_q <= fifo_data;
        WORD_VAL: begin
          minval_q <= cost;
          hit_q    <= cost_hit;
        end
        default: ;
      endcase
    end
  end

  // Sticky format error for cost words with bits above the cost width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fmt_err_q <= 1'b0;
    end else if (clear) begin
      fmt_err_q <= 1'b0;
    end else if (val_pop && cost_bad) begin
      fmt_err_q <= 1'b1;
    end
  end

  dtw_sat_counter #(
    .width (axi_dwidth)
  ) u_rec_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (val_pop),
    .clr   (clear),
    .count (rec_count)
  );

  dtw_sat_counter #(
    .width (axi_dwidth)
  ) u_hit_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (val_pop && cost_hit),
    .clr   (clear),
    .count (hit_count)
  );

  assign res.res_qid      = qid_q;
  assign res.res_position = position_q;
  assign res.res_minval   = minval_q;
  assign res.res_hit      = hit_q;
  assign fmt_err          = fmt_err_q;

endmodule

// File: tb/tb_dtw_result_unpacker.sv
// Scoreboard bench for dtw_result_unpacker with a behavioural FWFT FIFO.
module tb_dtw_result_unpacker;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          filter_en = 1'b0;
  logic [AW-1:0] threshold = '0;
  logic          fifo_rden;
  logic          fifo_empty = 1'b1;
  logic [AW-1:0] fifo_data = '0;
  logic [AW-1:0] rec_count;
  logic [AW-1:0] hit_count;
  logic          fmt_err;

  dtw_result_unpacker_if #(.dtw_dwidth(DW), .axi_dwidth(AW)) rif ();

  dtw_result_unpacker #(
    .dtw_dwidth (DW),
    .axi_dwidth (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .filter_en  (filter_en),
    .threshold  (threshold),
    .fifo_rden  (fifo_rden),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .res        (rif.master),
    .rec_count  (rec_count),
    .hit_count  (hit_count),
    .fmt_err    (fmt_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] qid;
    logic [31:0] pos;
    logic [15:0] minval;
    logic        hit;
  } rec_t;

  rec_t        exp_q[$];
  logic [31:0] fq[$];
  int          n_tests = 0;
  int          n_fail = 0;
  logic        rd_neg = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic void fifo_sync();
    fifo_empty = (fq.size() == 0);
    fifo_data  = (fq.size() == 0) ? 32'h0 : fq[0];
  endfunction

  // FIFO model: a pop seen on the negedge is applied just after the next edge.
  always @(negedge clk) rd_neg = fifo_rden;

  always @(posedge clk) begin
    logic pop_now;
    pop_now = rd_neg && rst_n;
    #1;
    if (pop_now && fq.size() > 0) void'(fq.pop_front());
    fifo_sync();
  end

  // Monitor: every accepted record must match the oldest expected one.
  always @(negedge clk) begin
    rec_t e;
    if (rst_n && rif.res_valid && rif.res_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_record: got qid 0x%0h, expected none", rif.res_qid);
      end else begin
        e = exp_q.pop_front();
        check("res_qid", rif.res_qid, e.qid);
        check("res_position", rif.res_position, e.pos);
        check("res_minval", 32'(rif.res_minval), 32'(e.minval));
        check("res_hit", 32'(rif.res_hit), 32'(e.hit));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [31:0] w);
    fq.push_back(w);
    fifo_sync();
  endtask

  task automatic push_rec(input logic [31:0] q, input logic [31:0] p, input logic [31:0] v,
                          input logic kept, input logic hit);
    rec_t e;
    push(q);
    push(p);
    push(v);
    if (kept) begin
      e.qid = q;
      e.pos = p;
      e.minval = v[15:0];
      e.hit = hit;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(input string name);
    bit done = 0;
    for (int i = 0; i < 80 && !done; i++) begin
      @(negedge clk);
      if (fq.size() == 0 && !rif.res_valid) done = 1;
    end
    check({name, "_drain"}, 32'(done), 32'd1);
  endtask

  task automatic wait_valid(input string name);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (rif.res_valid) seen = 1;
    end
    check({name, "_valid_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t dummy;
    rif.res_ready = 1'b1;
    threshold     = 32'h80;
    filter_en     = 1'b0;
    fifo_sync();

    // Reset state, with a record already waiting in the FIFO.
    push_rec(32'h11, 32'h2A0, 32'h50, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    check("rst_rden", 32'(fifo_rden), 32'd0);
    check("rst_valid", 32'(rif.res_valid), 32'd0);
    check("rst_rec_count", rec_count, 32'd0);
    check("rst_hit_count", hit_count, 32'd0);
    check("rst_fmt_err", 32'(fmt_err), 32'd0);
    check("rst_qid", rif.res_qid, 32'd0);

    // Basic record: three pops on consecutive cycles, valid the cycle after.
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t1_rden_pop", 32'(fifo_rden), 32'd1);
      check("t1_no_valid_yet", 32'(rif.res_valid), 32'd0);
    end
    @(negedge clk);
    check("t1_valid", 32'(rif.res_valid), 32'd1);
    check("t1_rden_out", 32'(fifo_rden), 32'd0);
    check("t1_rec_count", rec_count, 32'd1);
    check("t1_hit_count", hit_count, 32'd1);

    // Filter drop (minval == threshold is not a hit), next record pops at once.
    step();
    threshold = 32'h50;
    filter_en = 1'b1;
    push_rec(32'h12, 32'h300, 32'h50, 1'b0, 1'b0);
    push_rec(32'h13, 32'h301, 32'h10, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    @(negedge clk);
    check("t2_drop_no_valid", 32'(rif.res_valid), 32'd0);
    check("t2_next_pop", 32'(fifo_rden), 32'd1);
    drain("t2");
    check("t2_rec_count", rec_count, 32'd3);
    check("t2_hit_count", hit_count, 32'd2);

    // Backpressure: record held stable, FIFO stalled behind it.
    step();
    filter_en     = 1'b0;
    threshold     = 32'h80;
    rif.res_ready = 1'b0;
    push_rec(32'h21, 32'h400, 32'h90, 1'b1, 1'b0);
    push_rec(32'h22, 32'h401, 32'h7F, 1'b1, 1'b1);
    wait_valid("t3");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t3_stall_rden", 32'(fifo_rden), 32'd0);
      check("t3_stall_valid", 32'(rif.res_valid), 32'd1);
      check("t3_stall_qid", rif.res_qid, 32'h21);
      check("t3_stall_minval", 32'(rif.res_minval), 32'h90);
    end
    check("t3_fifo_level", 32'(fq.size()), 32'd3);
    step();
    rif.res_ready = 1'b1;
    drain("t3");
    check("t3_rec_count", rec_count, 32'd5);
    check("t3_hit_count", hit_count, 32'd3);

    // Format error is sticky across later clean records.
    step();
    push_rec(32'h31, 32'h500, 32'h0001_0020, 1'b1, 1'b1);
    drain("t4a");
    check("t4_fmt_err_set", 32'(fmt_err), 32'd1);
    step();
    push_rec(32'h32, 32'h501, 32'h40, 1'b1, 1'b1);
    drain("t4b");
    check("t4_fmt_err_sticky", 32'(fmt_err), 32'd1);
    check("t4_rec_count", rec_count, 32'd7);

    // FIFO runs dry before the cost word: wait in S_VAL without popping.
    step();
    push(32'h5);
    push(32'h7);
    dummy.qid = 32'h5;
    dummy.pos = 32'h7;
    dummy.minval = 16'h33;
    dummy.hit = 1'b1;
    exp_q.push_back(dummy);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t5_wait_rden", 32'(fifo_rden), 32'd0);
      check("t5_wait_valid", 32'(rif.res_valid), 32'd0);
    end
    step();
    push(32'h33);
    drain("t5");
    check("t5_rec_count", rec_count, 32'd8);
    check("t5_hit_count", hit_count, 32'd6);

    // Clear pulsed in S_POS aborts the record and zeroes statistics.
    step();
    push(32'h41);
    push(32'h42);
    push(32'h43);
    step();
    clear = 1'b1;
    @(negedge clk);
    check("t6_clear_no_pop", 32'(fifo_rden), 32'd0);
    fq.delete();
    fifo_sync();
    step();
    clear = 1'b0;
    @(negedge clk);
    check("t6_rec_count", rec_count, 32'd0);
    check("t6_hit_count", hit_count, 32'd0);
    check("t6_fmt_err", 32'(fmt_err), 32'd0);
    check("t6_valid", 32'(rif.res_valid), 32'd0);
    step();
    push_rec(32'h51, 32'h52, 32'h10, 1'b1, 1'b1);
    drain("t6");
    check("t6_rec_after", rec_count, 32'd1);

    // Asynchronous reset while a record is presented.
    step();
    rif.res_ready = 1'b0;
    push_rec(32'h61, 32'h62, 32'h63, 1'b0, 1'b1);
    wait_valid("t7");
    step();
    rst_n = 1'b0;
    #1;
    check("t7_valid", 32'(rif.res_valid), 32'd0);
    check("t7_qid", rif.res_qid, 32'd0);
    check("t7_position", rif.res_position, 32'd0);
    check("t7_minval", 32'(rif.res_minval), 32'd0);
    check("t7_hit", 32'(rif.res_hit), 32'd0);
    check("t7_rec_count", rec_count, 32'd0);
    check("t7_hit_count", hit_count, 32'd0);
    check("t7_rden", 32'(fifo_rden), 32'd0);
    fq.delete();
    fifo_sync();
    step();
    rst_n = 1'b1;
    rif.res_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
